// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM of the multicycle 32-bit RISC core. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback. The block
// drives every datapath enable and mux select, stalls memory accesses on
// mem_ready, and counts retired legal instructions.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   opcode[5:0]  in   instruction[31:26], sampled only in DECODE
//   mem_ready    in   memory finishes the current read/write this cycle
//   ALUOp[2:0]   out  000 add, 001 sub, 010 funct, 011 addi, 100 andi,
//                     101 ori, 110 slti
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA   out  datapath controls
//   ALUSrcB[1:0] out  00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   PCSource[1:0]out  00 ALU result, 01 ALUOut, 10 jump target
//   instr_done   out  one-cycle pulse in the final state of a legal instr
//   illegal_op   out  one-cycle pulse for an undecodable opcode
//   instr_count  out  retired legal instruction count (wraps)
//   o_state[3:0] out  current FSM state, for debug and checker binding
//
// Handshake: mem_ready is a completion strobe. In FETCH, MEM_RD and MEM_WR
// the FSM holds (outputs constant) every cycle mem_ready is 0 and advances
// in the first cycle it is 1; mem_ready is ignored in every other state.
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [2:0]       ALUOp,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       o_state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_count;

  assign o_state     = r_state;
  assign instr_count = r_count;

  // State register. op_q captures the opcode in DECODE so later opcode
  // changes cannot disturb sequencing or ALUOp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op_q <= opcode;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:      w_next = S_FETCH;
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                       w_next = S_MEM_ADDR;
          OP_R:                               w_next = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  w_next = S_EXEC_I;
          OP_BEQ:                             w_next = S_BRANCH;
          OP_J:                               w_next = S_JUMP;
          default:                            w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: w_next = (r_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC_R:   w_next = S_WB_R;
      S_WB_R:     w_next = S_FETCH;
      S_EXEC_I:   w_next = S_WB_I;
      S_WB_I:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_ILLEGAL:  w_next = S_FETCH;
      default:    w_next = S_RST;
    endcase
  end

  // Output decode: a function of state only, except FETCH (IRWrite/PCWrite
  // gated by mem_ready) and MEM_WR (instr_done in the completing cycle).
  always_comb begin
    ALUOp       = 3'b000;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (r_op_q)
          OP_ADDI: ALUOp = 3'b011;
          OP_ANDI: ALUOp = 3'b100;
          OP_ORI:  ALUOp = 3'b101;
          OP_SLTI: ALUOp = 3'b110;
          default: ALUOp = 3'b000;
        endcase
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (instr_done) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
